// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W0..W63 using a
// 16-word sliding window, expanding W16..W63 on the fly.

module sha256_s0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module sha256_s1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_schedule (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [15:0][31:0]  window;
    logic [5:0]         t;
    logic               load, advance;
    logic [31:0]        s0_out, s1_out, w_new;

    sha256_s0 u_s0 (.x(window[1]),  .y(s0_out));
    sha256_s1 u_s1 (.x(window[14]), .y(s1_out));

    // W[t+16]; also computed for t >= 48, where the result simply falls off the end
    assign w_new = s1_out + window[9] + s0_out + window[0];

    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        w_valid   = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    advance = 1'b1;
                    if (t == 6'd63)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            window <= '0;
            t      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                for (int i = 0; i < 16; i++)
                    window[i] <= blk_data[511 - 32*i -: 32];
                t <= '0;
            end else if (advance) begin
                window <= {w_new, window[15:1]};
                t      <= t + 6'd1;  // wraps 63 -> 0 on the final word
            end
        end
    end

    assign w_data = w_valid ? window[0] : 32'd0;
    assign w_idx  = t;
    assign w_last = w_valid && (t == 6'd63);
    assign busy   = (state == RUN);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: known blocks, backpressure,
// back-to-back blocks and mid-block reset, against a software schedule model.

module tb_sha256_msg_schedule;
    logic         aclk = 1'b0;
    logic         aresetn;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mw  [64];
    logic [31:0] got [64];

    sha256_msg_schedule dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sg0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sg1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build(input logic [511:0] b);
        for (int i = 0; i < 16; i++)
            mw[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            mw[i] = sg1(mw[i-2]) + mw[i-7] + sg0(mw[i-15]) + mw[i-16];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents blk, streams all 64 words checking each one. hold_valid/nxt set what
    // upstream shows after acceptance; abort_at < 64 pulses reset while W[abort_at] is shown.
    task automatic stream(input logic [511:0] blk, input string tag, input bit bp,
                          input bit hold_valid, input logic [511:0] nxt, input int abort_at);
        int k;
        int cyc;
        chk({tag, " idle blk_ready"}, blk_ready, 1);
        chk({tag, " idle w_valid"}, w_valid, 0);
        build(blk);
        blk_valid = 1'b1;
        blk_data  = blk;
        w_ready   = 1'b1;
        @(posedge aclk); #1;
        blk_valid = hold_valid;
        blk_data  = nxt;
        k   = 0;
        cyc = 0;
        while (k < 64 && cyc < 2000) begin
            if (k == abort_at) begin
                aresetn = 1'b0;
                #1;
                chk({tag, " rst w_valid"}, w_valid, 0);
                chk({tag, " rst blk_ready"}, blk_ready, 1);
                chk({tag, " rst w_idx"}, w_idx, 0);
                chk({tag, " rst w_data"}, w_data, 0);
                chk({tag, " rst busy"}, busy, 0);
                @(posedge aclk); #1;
                aresetn = 1'b1;
                return;
            end
            w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            chk($sformatf("%s w_valid[%0d]", tag, k), w_valid, 1);
            chk($sformatf("%s w_idx[%0d]", tag, k), w_idx, 64'(k));
            chk($sformatf("%s w_data[%0d]", tag, k), w_data, mw[k]);
            chk($sformatf("%s w_last[%0d]", tag, k), w_last, (k == 63) ? 1 : 0);
            chk($sformatf("%s blk_ready[%0d]", tag, k), blk_ready, 0);
            chk($sformatf("%s busy[%0d]", tag, k), busy, 1);
            got[k] = w_data;
            @(posedge aclk); #1;
            if (w_ready) k++;
            cyc++;
        end
        chk({tag, " words done within budget"}, 64'(k), 64);
        w_ready = 1'b1;
        chk({tag, " end blk_ready"}, blk_ready, 1);
        chk({tag, " end w_valid"}, w_valid, 0);
        chk({tag, " end w_idx"}, w_idx, 0);
        chk({tag, " end w_last"}, w_last, 0);
        chk({tag, " end busy"}, busy, 0);
    endtask

    logic [511:0] abc, ones, zero;

    initial begin
        abc  = {32'h61626380, 448'h0, 32'h00000018};
        ones = {512{1'b1}};
        zero = '0;

        aresetn   = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset blk_ready", blk_ready, 1);
        chk("reset w_valid", w_valid, 0);
        chk("reset w_data", w_data, 0);
        chk("reset w_idx", w_idx, 0);
        chk("reset w_last", w_last, 0);
        chk("reset busy", busy, 0);
        blk_valid = 1'b1;   // must not be accepted while in reset
        @(posedge aclk); #1;
        chk("reset no accept", w_valid, 0);
        blk_valid = 1'b0;
        aresetn   = 1'b1;
        @(posedge aclk); #1;

        stream(abc, "abc", 0, 0, '0, 64);
        chk("abc W0",  got[0],  32'h61626380);
        chk("abc W15", got[15], 32'h00000018);
        chk("abc W16", got[16], 32'h61626380);
        chk("abc W17", got[17], 32'h000F0000);

        stream(ones, "ones", 0, 0, '0, 64);
        chk("ones W0",  got[0],  32'hFFFFFFFF);
        chk("ones W16", got[16], 32'h203FFFFC);

        stream(zero, "zero", 0, 0, '0, 64);
        chk("zero W63", got[63], 32'h0);

        stream(abc, "abc_bp", 1, 0, '0, 64);
        chk("abc_bp W17", got[17], 32'h000F0000);

        // Upstream keeps blk_valid high; second block is taken only back in IDLE
        stream(abc,  "b2b_a", 0, 1, ones, 64);
        stream(ones, "b2b_b", 0, 0, '0, 64);
        chk("b2b_b W16", got[16], 32'h203FFFFC);

        stream(ones, "abort", 0, 0, '0, 30);
        stream(abc,  "post_rst", 0, 0, '0, 64);
        chk("post_rst W17", got[17], 32'h000F0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Message-schedule stage of the digital-signature SHA-256 datapath. Accepts one 512-bit padded message block and streams the 64 schedule words W0..W63, one 32-bit word per handshake, to the downstream compression-round engine. Words W16..W63 are expanded on the fly with the σ0/σ1 small-sigma functions, using a 16-word sliding window; no 64-word storage. Sits between the block padder (upstream) and the round engine (downstream).

## Interface
- No parameters; the SHA-256 word width (32) and round count (64) are fixed.
- aclk  in  1  single clock; all state changes on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- blk_valid  in  1  upstream block available
- blk_ready  out  1  stage can accept a block
- blk_data  in  512  padded block, big-endian word order: M0 = blk_data[511:480], M15 = blk_data[31:0]
- w_valid  out  1  schedule word valid
- w_ready  in  1  round engine accepts word
- w_data  out  32  schedule word W[w_idx]
- w_idx  out  6  round index t of w_data, 0..63
- w_last  out  1  high when w_idx == 63 and w_valid
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN.
- IDLE: blk_ready = 1, w_valid = 0. On blk_valid && blk_ready: window[i] <= M_i for i = 0..15, w_idx <= 0, go to RUN.
- RUN: blk_ready = 0, w_valid = 1, w_data = window[0], w_idx = t.
- On w_valid && w_ready in RUN (word W_t consumed):
  - new = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32 (carries beyond bit 31 discarded);
  - window[i] <= window[i+1] for i = 0..14, window[15] <= new (new = W_{t+16});
  - w_idx <= t+1; if t == 63 go to IDLE (w_idx returns to 0).
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x); reuse the existing s0/s1 function modules.
- Expansion runs for t = 48..63 too; those results are discarded, no special-casing required.
- blk_valid while in RUN is ignored (not accepted, no side effects); upstream holds it.
- Reset (aresetn low, any time incl. mid-block): state <= IDLE, window cleared, block in flight dropped; the round engine is reset by the same aresetn.
- Reset values: blk_ready 1 (state IDLE; no handshake counts while aresetn low), w_valid 0, w_data 0, w_idx 0, w_last 0, busy 0.

## Timing
- Block accepted at edge N → w_valid = 1 with W0 from cycle N+1.
- With w_ready held high: W_t presented in cycle N+1+t, W63 (w_last) in cycle N+64, blk_ready = 1 in cycle N+65.
- Throughput: 1 block per 65 cycles when neither side stalls (one IDLE bubble between blocks).
- Backpressure: while w_valid && !w_ready, w_data, w_idx, w_last are held stable; window does not advance.
- w_valid never drops in RUN until the W63 handshake.
- Critical path: two 32-bit XOR trees + 4-input 32-bit add, one cycle; no pipelining inside the expansion.

## Test plan
- "abc" padded block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1 → W0 = 0x61626380, W15 = 0x18, W16 = 0x61626380, W17 = 0x000F0000; W0..W63 match software model; w_last only on idx 63, cycle N+64.
- All-ones block (every M_i = 0xFFFFFFFF) → W16 = 0x203FFFFC (checks mod-2^32 wrap); remaining words match model.
- All-zero block → all 64 words 0x00000000, w_idx 0..63 in order, blk_ready returns at N+65.
- Random w_ready backpressure (~50% duty) on "abc" block → identical 64-word sequence; outputs stable during every stall cycle.
- blk_valid held high with two back-to-back blocks → second accepted only in IDLE at N+65; its words follow with no corruption from the first.
- aresetn pulsed low at t = 30 during a block → w_valid 0, blk_ready 1, w_idx 0 immediately; next block after release streams from W0 correctly.
